// File: rtl/tnn_enc_pkg.sv
// Shared types and helpers for the temporal spike encoder.
package tnn_enc_pkg;

   // Default spike-time width used by the column.
   localparam int DEF_TW  = 3;
   // Widest spike time and packed time vector that unpack_time handles.
   localparam int MAX_TW  = 8;
   localparam int MAX_VEC = 256;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } enc_state_e;

   typedef logic [DEF_TW-1:0] spike_time_t;

   // Extract channel i's time from a packed vector of tw-bit fields.
   function automatic logic [MAX_TW-1:0] unpack_time(input logic [MAX_VEC-1:0] vec,
                                                     input int unsigned       i,
                                                     input int unsigned       tw);
      logic [MAX_VEC-1:0] w_shifted;
      w_shifted = vec >> (i * tw);
      return w_shifted[MAX_TW-1:0] & MAX_TW'((32'd1 << tw) - 32'd1);
   endfunction

endpackage

// File: rtl/spike_time_encoder_channel.sv
// One encoder channel: stored time and mask, time==count match, spike register.
module enc_channel
#(
   parameter int TW = 3
)
(
   input  logic          clk,
   input  logic          grst,
   input  logic          i_load,
   input  logic [TW-1:0] i_time,
   input  logic          i_mask,
   input  logic          i_clear,
   input  logic          i_run,
   input  logic          i_abort,
   input  logic [TW:0]   i_count,
   output logic          o_spike
);

   logic [TW-1:0] r_time;
   logic          r_mask;
   logic          r_spike;
   logic          w_hit;

   // Zero-extend the stored time so times >= 2**TW-range counts never match falsely.
   assign w_hit = i_run & ~i_abort & r_mask & ({1'b0, r_time} == i_count);

   // Capture the channel's time and enable on an accepted load; drop the enable on a cancel.
   // NOTE: the stored vector is reset too, so a window started after reset can never replay stale times.
   always_ff @(posedge clk or posedge grst) begin
      if (grst) begin
         r_time <= '0;
         r_mask <= 1'b0;
      end else if (i_load) begin
         r_time <= i_time;
         r_mask <= i_mask;
      end else if (i_clear) begin
         r_mask <= 1'b0;
      end
   end

   // Register the single-cycle spike; an abort suppresses it on the same edge.
   // NOTE: non-blocking assignment keeps every flop sampling pre-edge values.
   always_ff @(posedge clk or posedge grst) begin
      if (grst) r_spike <= 1'b0;
      else      r_spike <= w_hit;
   end

   assign o_spike = r_spike;

endmodule

// File: rtl/spike_time_encoder.sv
// Transmit side of the temporal spike interface: window FSM, unit-time counter
// and NUM_CH spike channels.
module spike_time_encoder
   import tnn_enc_pkg::*;
#(
   parameter int NUM_CH    = 8,
   parameter int TW        = 3,
   parameter int GAMMA_LEN = 8
)
(
   input  logic                 clk,
   input  logic                 grst,
   input  logic                 load_valid,
   output logic                 load_ready,
   input  logic [NUM_CH*TW-1:0] load_times,
   input  logic [NUM_CH-1:0]    load_mask,
   input  logic                 start,
   input  logic                 abort,
   output logic [NUM_CH-1:0]    spike_out,
   output logic                 busy,
   output logic                 done,
   output logic [TW-1:0]        t_now
);

   // One extra bit so GAMMA_LEN == 2**TW does not wrap the final count.
   localparam int            CW   = TW + 1;
   localparam logic [CW-1:0] LAST = CW'(GAMMA_LEN - 1);

   enc_state_e    r_state;
   logic [CW-1:0] r_count;
   logic          r_go;
   logic          r_load_ready;
   logic          r_busy;
   logic          r_done;

   logic          w_load;
   logic          w_run;
   logic          w_discard;

   assign w_load    = (r_state == IDLE) & load_valid & r_load_ready;
   assign w_run     = (r_state == RUN);
   assign w_discard = abort & ((r_state == ARMED) | (r_state == RUN));

   // Window FSM and counter. A start seen in ARMED arms r_go, and RUN begins one
   // edge later, so the spike for time t lands after edge s+2+t and the final
   // spike coincides with the DONE cycle.
   always_ff @(posedge clk or posedge grst) begin
      if (grst) begin
         r_state      <= IDLE;
         r_count      <= '0;
         r_go         <= 1'b0;
         r_load_ready <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_go    <= 1'b0;
               r_count <= '0;
               if (w_load) begin
                  r_state      <= ARMED;
                  r_load_ready <= 1'b0;
                  r_busy       <= 1'b1;
               end else begin
                  r_load_ready <= 1'b1;
                  r_busy       <= 1'b0;
               end
            end
            ARMED: begin
               if (abort) begin
                  r_state      <= IDLE;
                  r_go         <= 1'b0;
                  r_load_ready <= 1'b1;
                  r_busy       <= 1'b0;
               end else if (r_go) begin
                  r_state <= RUN;
                  r_go    <= 1'b0;
                  r_count <= '0;
               end else if (start) begin
                  r_go <= 1'b1;
               end
            end
            RUN: begin
               if (abort) begin
                  r_state      <= IDLE;
                  r_count      <= '0;
                  r_load_ready <= 1'b1;
                  r_busy       <= 1'b0;
               end else if (r_count == LAST) begin
                  r_state <= DONE;
                  r_count <= '0;
                  r_done  <= 1'b1;
               end else begin
                  r_count <= r_count + 1'b1;
               end
            end
            DONE: begin
               r_state      <= IDLE;
               r_load_ready <= 1'b1;
               r_busy       <= 1'b0;
            end
            default: begin
               r_state      <= IDLE;
               r_count      <= '0;
               r_go         <= 1'b0;
               r_load_ready <= 1'b0;
               r_busy       <= 1'b0;
            end
         endcase
      end
   end

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [TW-1:0] w_time;

      assign w_time = TW'(unpack_time(MAX_VEC'(load_times), gi, TW));

      enc_channel #(.TW(TW)) u_ch (
         .clk     (clk),
         .grst    (grst),
         .i_load  (w_load),
         .i_time  (w_time),
         .i_mask  (load_mask[gi]),
         .i_clear (w_discard),
         .i_run   (w_run),
         .i_abort (abort),
         .i_count (r_count),
         .o_spike (spike_out[gi])
      );
   end

   assign load_ready = r_load_ready;
   assign busy       = r_busy;
   assign done       = r_done;
   // The counter is held at 0 outside RUN, so it doubles as t_now.
   assign t_now      = r_count[TW-1:0];

endmodule

// File: tb/tb_spike_time_encoder.sv
// Directed bench for spike_time_encoder: a default instance (TW=3) and a TW=4
// instance for out-of-range times, sharing clock and control inputs.
module tb_spike_time_encoder;

   logic        clk;
   logic        grst;
   logic        load_valid;
   logic        start;
   logic        abort;
   logic [23:0] times_a;
   logic [31:0] times_b;
   logic [7:0]  mask;

   logic        ready_a, busy_a, done_a;
   logic [7:0]  spk_a;
   logic [2:0]  tnow_a;
   logic        ready_b, busy_b, done_b;
   logic [7:0]  spk_b;
   logic [3:0]  tnow_b;

   int n_checks = 0;
   int n_fail   = 0;

   spike_time_encoder #(.NUM_CH(8), .TW(3), .GAMMA_LEN(8)) u_dut_a (
      .clk        (clk),
      .grst       (grst),
      .load_valid (load_valid),
      .load_ready (ready_a),
      .load_times (times_a),
      .load_mask  (mask),
      .start      (start),
      .abort      (abort),
      .spike_out  (spk_a),
      .busy       (busy_a),
      .done       (done_a),
      .t_now      (tnow_a)
   );

   spike_time_encoder #(.NUM_CH(8), .TW(4), .GAMMA_LEN(8)) u_dut_b (
      .clk        (clk),
      .grst       (grst),
      .load_valid (load_valid),
      .load_ready (ready_b),
      .load_times (times_b),
      .load_mask  (mask),
      .start      (start),
      .abort      (abort),
      .spike_out  (spk_b),
      .busy       (busy_b),
      .done       (done_b),
      .t_now      (tnow_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load_vec(input string tag, input logic [23:0] ta,
                           input logic [31:0] tb_v, input logic [7:0] m);
      load_valid = 1'b1;
      times_a    = ta;
      times_b    = tb_v;
      mask       = m;
      tick();
      load_valid = 1'b0;
      check({tag, " busy after load"}, 32'(busy_a), 32'd1);
      check({tag, " ready after load"}, 32'(ready_a), 32'd0);
   endtask

   // Start a window from ARMED and check edges s..s+10; exp_seq[k*8 +: 8] is the
   // spike vector expected in the cycle after edge s+k.
   task automatic run_window(input string tag, input bit use_b, input logic [87:0] exp_seq);
      logic [7:0] spk;
      logic       d, b, r;
      logic [3:0] tn;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k <= 10; k++) begin
         if (k > 0) tick();
         spk = use_b ? spk_b   : spk_a;
         d   = use_b ? done_b  : done_a;
         b   = use_b ? busy_b  : busy_a;
         r   = use_b ? ready_b : ready_a;
         tn  = use_b ? tnow_b  : {1'b0, tnow_a};
         check($sformatf("%s k=%0d spike", tag, k), 32'(spk), 32'(exp_seq[k*8 +: 8]));
         check($sformatf("%s k=%0d done", tag, k), 32'(d), 32'(k == 9));
         check($sformatf("%s k=%0d busy", tag, k), 32'(b), 32'(k <= 9));
         check($sformatf("%s k=%0d ready", tag, k), 32'(r), 32'(k >= 10));
         check($sformatf("%s k=%0d t_now", tag, k), 32'(tn),
               (k >= 1 && k <= 8) ? 32'(k - 1) : 32'd0);
      end
   endtask

   // Channel i time 7-i: ch7 fires after s+2 down to ch0 after s+9.
   localparam logic [23:0] RAMP_A   = 24'o01234567;
   localparam logic [87:0] RAMP_EXP = 88'h00_01_02_04_08_10_20_40_80_00_00;

   initial begin
      grst       = 1'b1;
      load_valid = 1'b0;
      start      = 1'b0;
      abort      = 1'b0;
      times_a    = '0;
      times_b    = '0;
      mask       = '0;

      // Reset state, held across clock edges.
      #1;
      check("rst spike", 32'(spk_a), 32'd0);
      check("rst done", 32'(done_a), 32'd0);
      check("rst busy", 32'(busy_a), 32'd0);
      check("rst t_now", 32'(tnow_a), 32'd0);
      tick();
      tick();
      check("rst ready held", 32'(ready_a), 32'd0);
      check("rst ready held b", 32'(ready_b), 32'd0);
      grst = 1'b0;
      tick();
      check("ready after release", 32'(ready_a), 32'd1);
      check("busy after release", 32'(busy_a), 32'd0);

      // Ramp of times, full mask.
      load_vec("ramp", RAMP_A, 32'h0, 8'hFF);
      run_window("ramp", 1'b0, RAMP_EXP);

      // Equal times, partial mask.
      load_vec("mask", 24'o33333333, 32'h0, 8'hA5);
      run_window("mask", 1'b0, 88'h00_00_00_00_00_A5_00_00_00_00_00);

      // TW=4: ch0 time 9, ch1 time 8 out of range; ch2 time 2 masked off.
      load_vec("range", RAMP_A, 32'h7654_3289, 8'hFB);
      run_window("range", 1'b1, 88'h00_80_40_20_10_08_00_00_00_00_00);

      // Abort in RUN while t_now == 2.
      load_vec("abort", 24'o76543210, 32'h0, 8'hFF);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      check("abort k=1 spike", 32'(spk_a), 32'd0);
      tick();
      check("abort k=2 spike", 32'(spk_a), 32'h01);
      tick();
      check("abort k=3 spike", 32'(spk_a), 32'h02);
      check("abort k=3 t_now", 32'(tnow_a), 32'd2);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort k=4 spike", 32'(spk_a), 32'd0);
      check("abort k=4 busy", 32'(busy_a), 32'd0);
      check("abort k=4 ready", 32'(ready_a), 32'd1);
      check("abort k=4 t_now", 32'(tnow_a), 32'd0);
      for (int k = 5; k <= 10; k++) begin
         tick();
         check($sformatf("abort k=%0d spike", k), 32'(spk_a), 32'd0);
         check($sformatf("abort k=%0d done", k), 32'(done_a), 32'd0);
      end

      // Asynchronous gamma reset between clock edges mid-RUN.
      load_vec("grst", RAMP_A, 32'h0, 8'hFF);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 5; k++) tick();
      check("grst pre spike", 32'(spk_a), 32'h10);
      check("grst pre t_now", 32'(tnow_a), 32'd4);
      #3;
      grst = 1'b1;
      #1;
      check("grst spike", 32'(spk_a), 32'd0);
      check("grst done", 32'(done_a), 32'd0);
      check("grst busy", 32'(busy_a), 32'd0);
      check("grst t_now", 32'(tnow_a), 32'd0);
      check("grst ready", 32'(ready_a), 32'd0);
      #1;
      grst = 1'b0;
      tick();
      check("grst ready after", 32'(ready_a), 32'd1);
      load_vec("post grst", RAMP_A, 32'h0, 8'hFF);
      run_window("post grst", 1'b0, RAMP_EXP);

      // load_valid held high: only the IDLE offer is taken.
      load_valid = 1'b1;
      times_a    = RAMP_A;
      mask       = 8'hFF;
      tick();
      check("hold taken busy", 32'(busy_a), 32'd1);
      times_a = 24'o00000000;
      tick();
      tick();
      check("hold armed ready", 32'(ready_a), 32'd0);
      run_window("hold", 1'b0, RAMP_EXP);
      tick();
      check("hold retake busy", 32'(busy_a), 32'd1);
      check("hold retake ready", 32'(ready_a), 32'd0);
      abort = 1'b1;
      tick();
      abort      = 1'b0;
      load_valid = 1'b0;
      check("hold abort busy", 32'(busy_a), 32'd0);
      check("hold abort ready", 32'(ready_a), 32'd1);

      // start in IDLE with nothing loaded.
      start = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         tick();
         check($sformatf("idle start k=%0d spike", k), 32'(spk_a), 32'd0);
         check($sformatf("idle start k=%0d done", k), 32'(done_a), 32'd0);
         check($sformatf("idle start k=%0d busy", k), 32'(busy_a), 32'd0);
      end
      start = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/spike_time_encoder.md
Name: spike_time_encoder

Overview:
- Transmit side of the temporal spike interface. Accepts one vector of per-channel spike times per gamma window and emits a single-cycle spike pulse on each channel when the window's unit-time counter reaches that channel's time.
- It drives the spike-time inputs that the column's counting logic measures from gamma start.
- One encoder serves NUM_CH channels.
- The gamma reset clears it asynchronously at the start of every gamma cycle.

Parameters:
- NUM_CH, 8, number of spike channels.
- TW, 3, width of a spike time in unit-time cycles.
- GAMMA_LEN, 8, unit-time cycles per gamma window. Legal range is 2..2**TW.

Ports:
- clk  in  1  unit-time clock
- grst  in  1  reset (gamma reset), asynchronous, active-high
- load_valid  in  1  spike-time vector offered
- load_ready  out  1  encoder can accept a vector
- load_times  in  NUM_CH*TW  packed times; channel i occupies bits [i*TW +: TW]
- load_mask  in  NUM_CH  1 = channel fires; 0 = channel silent this window
- start  in  1  begin the gamma window
- abort  in  1  synchronous cancel of the current window
- spike_out  out  NUM_CH  single-cycle spike pulses
- busy  out  1  high in ARMED, RUN and DONE
- done  out  1  single-cycle end-of-window pulse
- t_now  out  TW  current window count (0 outside RUN)

Behaviour:
- Reset (grst=1, asynchronous):
  - State goes to IDLE.
  - Count, stored times, mask, spike_out, done and t_now all go to 0.
  - load_ready goes to 1 one clk edge after grst deasserts. It is held at 0 while grst is high.
- States: IDLE, ARMED, RUN, DONE.
- IDLE:
  - load_ready=1.
  - When load_valid is high at a clk edge, latch load_times and load_mask and move to ARMED.
  - start is ignored in IDLE.
- ARMED:
  - load_ready=0.
  - When start is high at a clk edge, move to RUN with count=0.
  - When abort is high, move to IDLE and discard the stored vector. abort takes priority over start.
- RUN:
  - count increments by 1 each cycle.
  - When count==GAMMA_LEN-1, move to DONE.
  - When abort is high, move to IDLE. Count clears and no done pulse is issued.
- DONE: lasts exactly one cycle with done=1, then moves to IDLE.
- Spike rule:
  - spike_out[i] is registered: spike_out[i] <= (state==RUN) & mask[i] & (time[i]==count).
  - If start is sampled at edge s, the spike for time t is high for exactly the one cycle following edge s+2+t (edges counted as clk cycles).
  - The done pulse coincides with the spike for t=GAMMA_LEN-1.
  - Each channel fires at most once per window.
  - Channels with time >= GAMMA_LEN never fire.
  - Channels with equal times fire in the same cycle.
- abort during RUN: spikes already emitted stand. spike_out clears at the next edge, so no further spikes are produced.
- t_now mirrors count in RUN and is 0 in all other states.
- Handshake: a transfer occurs only when load_valid & load_ready are both high at a clk edge. load_times and load_mask are sampled only at that edge. Vectors offered during busy are not taken.
- Arithmetic: count is TW+1 bits wide so that GAMMA_LEN==2**TW does not wrap. Comparisons zero-extend time[i].
- grst mid-operation: any state returns to IDLE immediately. Outputs clear without waiting for clk, and no done pulse is issued.

Decomposition:
- Shared package tnn_enc_pkg:
  - enc_state_e enum (IDLE, ARMED, RUN, DONE), 2 bits.
  - Typedef spike_time_t as logic [TW-1:0]. The package default TW is 3.
  - Function unpack_time(vec, i).
- One natural sub-module, enc_channel:
  - Holds the stored time and mask bit for one channel.
  - Contains the time==count comparator and the spike_out register.
  - Instantiated NUM_CH times in a generate loop. The top level holds the FSM and counter.

Test Plan:
- Reset, then load times {7,6,5,4,3,2,1,0}, mask 8'hFF, start at edge s:
  - spike_out[7] pulses one cycle after edge s+2, then [6] after s+3, and so on through [0] after s+9.
  - done coincides with the [0] spike.
  - busy falls the cycle after done; load_ready returns to 1.
- Load all times=3 with mask 8'hA5:
  - Only channels 0, 2, 5 and 7 pulse, together, after edge s+5.
  - spike_out is 0 in every other cycle.
- Out-of-range and silent channels, with TW=4, GAMMA_LEN=8 (count 0..7):
  - Load time 9 on channel 0 and time 8 on channel 1 → neither fires.
  - With mask bit 0 on a channel with time 2 → that channel does not fire.
  - done still pulses after edge s+9.
- abort asserted in RUN at count=2, with times {0..7}:
  - Spikes for times 0 and 1 are observed; no others.
  - No done pulse; state returns to IDLE and load_ready=1.
- grst pulsed asynchronously mid-RUN, between clk edges:
  - spike_out, done, busy and t_now go to 0 before the next edge.
  - After release, a fresh load/start sequence behaves as in the first scenario.
- load_valid held high throughout ARMED and RUN:
  - The vector is taken only in IDLE.
  - start issued in IDLE with no vector loaded produces no spikes and no done.
